// File: rtl/lsu_pkg.sv
// Shared constants, FSM encoding and request legality check for the load/store unit.
package lsu_pkg;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } lsuState_t;

  // Unsigned variants exist only for loads; halves and words must be naturally aligned.
  function automatic logic reqIllegal(input logic isStore, input logic [2:0] f3,
                                      input logic [1:0] adrLo);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = adrLo[0];
      F3_W:    bad = |adrLo;
      F3_BU:   bad = isStore;
      F3_HU:   bad = isStore | adrLo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      adrLo,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] storeData,
  output logic [XLEN-1:0] loadVal,
  output logic [XLEN-1:0] mergedWord
);

  logic [BYTE_W-1:0] laneByte;
  logic [HALF_W-1:0] laneHalf;

  always_comb begin
    laneByte = word[{adrLo, 3'b000} +: BYTE_W];
    laneHalf = word[{adrLo[1], 4'b0000} +: HALF_W];

    case (funct3)
      F3_B:    loadVal = {{(XLEN-BYTE_W){laneByte[BYTE_W-1]}}, laneByte};
      F3_H:    loadVal = {{(XLEN-HALF_W){laneHalf[HALF_W-1]}}, laneHalf};
      F3_BU:   loadVal = {{(XLEN-BYTE_W){1'b0}}, laneByte};
      F3_HU:   loadVal = {{(XLEN-HALF_W){1'b0}}, laneHalf};
      default: loadVal = word;
    endcase

    mergedWord = word;
    case (funct3)
      F3_B:    mergedWord[{adrLo, 3'b000} +: BYTE_W] = storeData[BYTE_W-1:0];
      F3_H:    mergedWord[{adrLo[1], 4'b0000} +: HALF_W] = storeData[HALF_W-1:0];
      F3_W:    mergedWord = storeData;
      default: mergedWord = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one RV32I load/store at a time, sub-word stores via read-modify-write.
//   state | meaning
//   IDLE  | waiting for start; request latched on accept
//   READ  | memRD captured into rdBuf; loads update loadData
//   WRITE | memWE asserted for one cycle with merged/full word
//   DONE  | done pulse, err reports an illegal request
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ALIGN_BITS = 2
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            start,
  input  logic            isStore,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] storeData,
  output logic [XLEN-1:0] loadData,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] memAdr,
  output logic [XLEN-1:0] memWD,
  output logic            memWE,
  input  logic [XLEN-1:0] memRD
);

  lsuState_t       state, nextState;
  logic [1:0]      reqAdrLo;
  logic [2:0]      reqF3;
  logic            reqStore;
  logic [XLEN-1:0] reqData;
  logic            errFlag;
  logic [XLEN-1:0] rdBuf;

  logic [XLEN-1:0] alignWord;
  logic [XLEN-1:0] loadVal;
  logic [XLEN-1:0] mergedWord;
  logic            startIllegal;

  assign startIllegal = reqIllegal(isStore, funct3, addr[1:0]);

  // Extraction works on live read data; the merge works on the word captured in READ.
  assign alignWord = (state == WRITE) ? rdBuf : memRD;

  lsu_lane_align #(.XLEN(XLEN)) uAlign (
    .word       (alignWord),
    .adrLo      (reqAdrLo),
    .funct3     (reqF3),
    .storeData  (reqData),
    .loadVal    (loadVal),
    .mergedWord (mergedWord)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      reqAdrLo <= '0;
      reqF3    <= '0;
      reqStore <= 1'b0;
      reqData  <= '0;
      errFlag  <= 1'b0;
      rdBuf    <= '0;
      loadData <= '0;
      memAdr   <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (start) begin
            reqAdrLo <= addr[1:0];
            reqF3    <= funct3;
            reqStore <= isStore;
            reqData  <= storeData;
            errFlag  <= startIllegal;
            memAdr   <= {addr[XLEN-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
          end
        end
        READ: begin
          rdBuf <= memRD;
          if (!reqStore) loadData <= loadVal;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nextState = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    err       = 1'b0;
    memWE     = 1'b0;
    memWD     = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if (startIllegal)                       nextState = DONE;
          else if (isStore && (funct3 == F3_W))   nextState = WRITE;
          else                                    nextState = READ;
        end
      end
      READ:  nextState = reqStore ? WRITE : DONE;
      WRITE: begin
        memWE     = !Rst;
        memWD     = mergedWord;
        nextState = DONE;
      end
      DONE: begin
        done      = 1'b1;
        err       = errFlag;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small word memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        start = 1'b0;
  logic        isStore = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] storeData = '0;
  logic [31:0] loadData, memAdr, memWD, memRD;
  logic        busy, done, err, memWE;

  logic [31:0] mem [16];
  logic        preWE = 1'b0;
  logic [3:0]  preIdx = '0;
  logic [31:0] preData = '0;

  int          edgeCnt = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] lastLoad = '0;

  typedef struct {int cyc; logic err; logic [31:0] ld; logic [31:0] adr;} doneExp_t;
  typedef struct {int cyc; logic [31:0] adr; logic [31:0] wd;} wrExp_t;
  doneExp_t doneQ[$];
  wrExp_t   wrQ[$];

  load_store_unit #(.XLEN(32), .ALIGN_BITS(2)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .isStore(isStore), .funct3(funct3),
    .addr(addr), .storeData(storeData), .loadData(loadData), .busy(busy),
    .done(done), .err(err), .memAdr(memAdr), .memWD(memWD), .memWE(memWE),
    .memRD(memRD)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) edgeCnt <= edgeCnt + 1;

  always @(posedge Clk) begin
    if (memWE) mem[memAdr[5:2]] <= memWD;
    else if (preWE) mem[preIdx] <= preData;
  end
  assign memRD = mem[memAdr[5:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (!Rst && done) begin
      if (doneQ.size() == 0) chk("doneSpurious", {31'b0, done}, 32'd0);
      else begin
        doneExp_t e;
        e = doneQ.pop_front();
        chk("doneCycle", edgeCnt, e.cyc);
        chk("doneErr", {31'b0, err}, {31'b0, e.err});
        chk("doneLoadData", loadData, e.ld);
        chk("doneMemAdr", memAdr, e.adr);
      end
    end
    if (memWE) begin
      if (wrQ.size() == 0) chk("writeSpurious", {31'b0, memWE}, 32'd0);
      else begin
        wrExp_t w;
        w = wrQ.pop_front();
        chk("writeCycle", edgeCnt, w.cyc);
        chk("writeAdr", memAdr, w.adr);
        chk("writeData", memWD, w.wd);
      end
    end
  end

  task automatic preload(input int idx, input logic [31:0] d);
    preIdx = idx[3:0]; preData = d; preWE = 1'b1;
    @(posedge Clk); #2;
    preWE = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 10) begin
      @(posedge Clk); #2;
      n++;
    end
    chk("idleTimeout", {31'b0, busy}, 32'd0);
  endtask

  // wrLat = 0 means no memory write is expected.
  task automatic req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input logic eErr, input logic [31:0] eLd,
                     input int lat, input int wrLat, input logic [31:0] eWd);
    doneExp_t de;
    wrExp_t   we;
    isStore = st; funct3 = f3; addr = a; storeData = d; start = 1'b1;
    de.cyc = edgeCnt + lat; de.err = eErr; de.ld = eLd; de.adr = {a[31:2], 2'b00};
    doneQ.push_back(de);
    if (wrLat > 0) begin
      we.cyc = edgeCnt + wrLat; we.adr = {a[31:2], 2'b00}; we.wd = eWd;
      wrQ.push_back(we);
    end
    @(posedge Clk); #2;
    start = 1'b0;
    waitIdle();
    @(posedge Clk); #2;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) preload(i, 32'h0);
    preload(2, 32'd20);
    preload(1, 32'h0000_0005);
    chk("rstLoadData", loadData, 32'h0);
    chk("rstBusy", {31'b0, busy}, 32'd0);
    chk("rstDone", {31'b0, done}, 32'd0);
    chk("rstErr", {31'b0, err}, 32'd0);
    chk("rstMemAdr", memAdr, 32'h0);
    chk("rstMemWE", {31'b0, memWE}, 32'd0);
    chk("rstMemWD", memWD, 32'h0);
    Rst = 1'b0;
    @(posedge Clk); #2;

    // word load
    lastLoad = 32'h0000_0014;
    req(1'b0, F3_W, 32'd8, 32'h0, 1'b0, lastLoad, 2, 0, 32'h0);

    // word store then sub-word loads with extension
    req(1'b1, F3_W, 32'd12, 32'h8081_F0FF, 1'b0, lastLoad, 2, 1, 32'h8081_F0FF);
    req(1'b0, F3_B,  32'd12, 32'h0, 1'b0, 32'hFFFF_FFFF, 2, 0, 32'h0);
    req(1'b0, F3_BU, 32'd13, 32'h0, 1'b0, 32'h0000_00F0, 2, 0, 32'h0);
    req(1'b0, F3_H,  32'd14, 32'h0, 1'b0, 32'hFFFF_8081, 2, 0, 32'h0);
    lastLoad = 32'h0000_8081;
    req(1'b0, F3_HU, 32'd14, 32'h0, 1'b0, lastLoad, 2, 0, 32'h0);

    // read-modify-write byte and half stores
    req(1'b1, F3_B, 32'd5, 32'hFFFF_FFAB, 1'b0, lastLoad, 3, 2, 32'h0000_AB05);
    req(1'b1, F3_H, 32'd6, 32'h1234_BEEF, 1'b0, lastLoad, 3, 2, 32'hBEEF_AB05);
    chk("memWord4AfterSh", mem[1], 32'hBEEF_AB05);

    // illegal requests: no write, loadData untouched
    req(1'b0, F3_W, 32'd6, 32'h0, 1'b1, lastLoad, 1, 0, 32'h0);
    req(1'b1, F3_H, 32'd3, 32'hDEAD_BEEF, 1'b1, lastLoad, 1, 0, 32'h0);
    req(1'b0, 3'b011, 32'd0, 32'h0, 1'b1, lastLoad, 1, 0, 32'h0);

    // reset during the WRITE cycle of SB addr 5
    isStore = 1'b1; funct3 = F3_B; addr = 32'd5; storeData = 32'h0000_0077; start = 1'b1;
    @(posedge Clk); #2;
    start = 1'b0;
    @(posedge Clk); #2;
    Rst = 1'b1;
    #1;
    chk("weUnderRst", {31'b0, memWE}, 32'd0);
    @(posedge Clk); #2;
    Rst = 1'b0;
    chk("abortLoadData", loadData, 32'h0);
    chk("abortBusy", {31'b0, busy}, 32'd0);
    chk("abortDone", {31'b0, done}, 32'd0);
    chk("abortErr", {31'b0, err}, 32'd0);
    chk("abortMemAdr", memAdr, 32'h0);
    chk("abortMemWE", {31'b0, memWE}, 32'd0);
    chk("abortMemWD", memWD, 32'h0);
    chk("abortMemWord4", mem[1], 32'hBEEF_AB05);
    lastLoad = 32'h0;
    repeat (3) @(posedge Clk);
    #2;

    // start held through READ and DONE of an LW is ignored
    isStore = 1'b0; funct3 = F3_W; addr = 32'd8; storeData = 32'h0; start = 1'b1;
    begin
      doneExp_t de;
      de.cyc = edgeCnt + 2; de.err = 1'b0; de.ld = 32'h0000_0014; de.adr = 32'd8;
      doneQ.push_back(de);
    end
    lastLoad = 32'h0000_0014;
    @(posedge Clk); #2;
    addr = 32'd12; funct3 = F3_B;
    @(posedge Clk); #2;
    @(posedge Clk); #2;
    start = 1'b0;
    chk("heldStartBusy", {31'b0, busy}, 32'd0);
    @(posedge Clk); #2;
    chk("heldStartStillIdle", {31'b0, busy}, 32'd0);

    req(1'b0, F3_BU, 32'd12, 32'h0, 1'b0, 32'h0000_00FF, 2, 0, 32'h0);

    repeat (3) @(posedge Clk);
    #2;
    chk("doneQEmpty", doneQ.size(), 32'd0);
    chk("wrQEmpty", wrQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL globalTimeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
